// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - interrupt controller: pending/mask/mode per source, priority claim, ack holdoff
module int_ctrl #(
  parameter int NSRC    = 3,
  parameter int HOLDOFF = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      Addr,
  input  logic            WE,
  input  logic [31:0]     Din,
  output logic [31:0]     Dout,
  input  logic [NSRC-1:0] IRQIn,
  output logic [5:0]      HWInt,
  output logic            IRQ
);

  // Counter wide enough for HOLDOFF; one bit minimum so HOLDOFF = 0 still elaborates.
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic [NSRC-1:0] irq_prev_q;
  logic [HW-1:0]   hold_q, hold_d;

  logic            pend_wr, mask_wr, mode_wr;
  logic [NSRC-1:0] w1c, rise;
  logic [31:0]     claim;
  logic            unused_din;

  assign pend_wr = WE && (Addr == 3'd0);
  assign mask_wr = WE && (Addr == 3'd1);
  assign mode_wr = WE && (Addr == 3'd2);
  assign w1c     = pend_wr ? Din[NSRC-1:0] : '0;
  assign rise    = IRQIn & ~irq_prev_q;

  // Data bits above the implemented sources are ignored on every register.
  assign unused_din = ^Din[31:NSRC];

  // Next pending state: edge sources latch rises (a rise beats a W1C), level sources follow the line.
  always_comb begin
    pend_d = (mode_q & (rise | (pend_q & ~w1c))) | (~mode_q & IRQIn);
    mask_d = mask_wr ? Din[NSRC-1:0] : mask_q;
    mode_d = mode_wr ? Din[NSRC-1:0] : mode_q;
  end

  // Holdoff: any acknowledge of a real source (re)starts the count, otherwise count down to zero.
  always_comb begin
    hold_d = hold_q;
    if (pend_wr && (Din[NSRC-1:0] != '0)) begin
      hold_d = HW'(HOLDOFF);
    end else if (hold_q != '0) begin
      hold_d = hold_q - HW'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q     <= '0;
      mask_q     <= '0;
      mode_q     <= '0;
      irq_prev_q <= '0;
      hold_q     <= '0;
    end else begin
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      mode_q     <= mode_d;
      irq_prev_q <= IRQIn;
      hold_q     <= hold_d;
    end
  end

  // Claim ID: lowest enabled pending source wins; holdoff is deliberately not applied here.
  always_comb begin
    claim = 32'hFFFF_FFFF;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pend_q[i] && mask_q[i]) begin
        claim = 32'(i);
      end
    end
  end

  // CPU interrupt lines, suppressed while the holdoff counter runs.
  always_comb begin
    HWInt = '0;
    for (int i = 0; i < NSRC; i++) begin
      HWInt[i] = pend_q[i] & mask_q[i] & (hold_q == '0);
    end
  end

  assign IRQ = |HWInt;

  // Register read mux; unused offsets read zero.
  always_comb begin
    case (Addr)
      3'd0:    Dout = 32'(pend_q);
      3'd1:    Dout = 32'(mask_q);
      3'd2:    Dout = 32'(mode_q);
      3'd3:    Dout = claim;
      3'd4:    Dout = 32'(IRQIn);
      default: Dout = 32'h0;
    endcase
  end

endmodule
